// File: rtl/ram_pack_ctrl_if.sv
// ram_pack_ctrl_if
//   Bundles the control, averager and RAM-write signals of ram_pack_ctrl.
//   master : the environment side. It drives start, clr, avg_*, ram_busy and
//            observes the RAM write port and the status flags.
//   slave  : the ram_pack_ctrl side.
//   Signals:
//     start, clr          frame start pulse, synchronous abort/clear
//     avg_valid, avg_data averaged byte stream
//     ram_busy            RAM cannot accept a write this cycle
//     wr_ram, ram_addr,   RAM write strobe, word address, packed word
//     ram_data
//     byte_cnt            lane for the next byte
//     ram_full            frame complete
//     overflow_err        sticky byte-drop flag
interface ram_pack_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic              clr;
  logic              avg_valid;
  logic [7:0]        avg_data;
  logic              ram_busy;
  logic              wr_ram;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_data;
  logic [1:0]        byte_cnt;
  logic              ram_full;
  logic              overflow_err;

  modport master (
    output start, clr, avg_valid, avg_data, ram_busy,
    input  wr_ram, ram_addr, ram_data, byte_cnt, ram_full, overflow_err
  );

  modport slave (
    input  start, clr, avg_valid, avg_data, ram_busy,
    output wr_ram, ram_addr, ram_data, byte_cnt, ram_full, overflow_err
  );
endinterface

// File: rtl/ram_pack_ctrl.sv
// ram_pack_ctrl
//   Packs four consecutive averaged bytes into a 32-bit word (byte_0 in
//   [7:0]) and writes it to the frame RAM. The word address steps from 0
//   to RAM_DEPTH-1 and stops in FULL. A one-byte holding register absorbs
//   input slip while a write and its recovery are in progress.
//   Ports:
//     clk_2  rising-edge clock
//     reset  synchronous, active-high reset
//     bus    ram_pack_ctrl_if.slave (control, byte stream, RAM write port)
module ram_pack_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int RAM_DEPTH = 2048,
  parameter int WAIT_CYC  = 1
) (
  input  logic           clk_2,
  input  logic           reset,
  ram_pack_ctrl_if.slave bus
);

  localparam int WCW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_WAIT,
    S_FULL
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0][7:0]   lane_q;
  logic [1:0]        cnt_q;
  logic [7:0]        hold_q;
  logic              hold_v;
  logic              full_q;
  logic              ovf_q;
  logic [WCW-1:0]    wait_cnt;
  logic              wait_last;
  logic              addr_last;

  assign wait_last = (wait_cnt == WCW'(WAIT_CYC - 1));
  assign addr_last = (addr_q == ADDR_W'(RAM_DEPTH - 1));

  // The strobe has to follow ram_busy in the same cycle, so it is decoded
  // from the state rather than registered. reset/clr on a WRITE cycle
  // suppress it: the word is abandoned along with the rest of the frame.
  assign bus.wr_ram       = (state == S_WRITE) && !bus.ram_busy && !reset && !bus.clr;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_data     = lane_q;
  assign bus.byte_cnt     = cnt_q;
  assign bus.ram_full     = full_q;
  assign bus.overflow_err = ovf_q;

  always_ff @(posedge clk_2) begin
    if (reset || bus.clr) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      lane_q   <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      hold_v   <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) state <= S_COLLECT;
        end

        S_COLLECT: begin
          if (bus.avg_valid) begin
            lane_q[cnt_q] <= bus.avg_data;
            cnt_q         <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state <= S_WRITE;
          end
        end

        S_WRITE: begin
          // A byte here goes to the holding register. A second one is lost.
          if (bus.avg_valid) begin
            if (hold_v) ovf_q <= 1'b1;
            else begin
              hold_q <= bus.avg_data;
              hold_v <= 1'b1;
            end
          end
          if (!bus.ram_busy) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end

        S_WAIT: begin
          if (!wait_last) begin
            wait_cnt <= wait_cnt + WCW'(1);
            if (bus.avg_valid) begin
              if (hold_v) ovf_q <= 1'b1;
              else begin
                hold_q <= bus.avg_data;
                hold_v <= 1'b1;
              end
            end
          end else if (addr_last) begin
            // Frame done. A held byte and any byte arriving now have no word to land in.
            state  <= S_FULL;
            full_q <= 1'b1;
            hold_v <= 1'b0;
            if (hold_v || bus.avg_valid) ovf_q <= 1'b1;
          end else begin
            // The next word starts on this edge. A held byte takes lane 0, so the
            // new byte in this cycle goes behind it.
            state  <= S_COLLECT;
            addr_q <= addr_q + ADDR_W'(1);
            if (hold_v) begin
              lane_q[0] <= hold_q;
              hold_v    <= 1'b0;
              if (bus.avg_valid) begin
                lane_q[1] <= bus.avg_data;
                cnt_q     <= 2'd2;
              end else begin
                cnt_q     <= 2'd1;
              end
            end else if (bus.avg_valid) begin
              lane_q[0] <= bus.avg_data;
              cnt_q     <= 2'd1;
            end
          end
        end

        S_FULL: begin
          if (bus.avg_valid) ovf_q <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_pack_ctrl.sv
// tb_ram_pack_ctrl
//   Directed bench for ram_pack_ctrl (RAM_DEPTH=4, WAIT_CYC=2). The main
//   process issues the stimulus and pushes each expected RAM write into a
//   queue. A monitor pops the queue on every wr_ram and compares address and
//   data. Status outputs are checked inline on the falling edge.
module tb_ram_pack_ctrl;
  localparam int ADDR_W    = 11;
  localparam int RAM_DEPTH = 4;
  localparam int WAIT_CYC  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk_2;
  logic reset;
  wr_t  exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   n_wr       = 0;

  ram_pack_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  ram_pack_ctrl #(
    .ADDR_W   (ADDR_W),
    .RAM_DEPTH(RAM_DEPTH),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk_2(clk_2),
    .reset(reset),
    .bus  (bus)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " wr_ram"},       32'(bus.wr_ram),       32'd0);
    chk({tag, " ram_addr"},     32'(bus.ram_addr),     32'd0);
    chk({tag, " byte_cnt"},     32'(bus.byte_cnt),     32'd0);
    chk({tag, " ram_data"},     bus.ram_data,          32'd0);
    chk({tag, " ram_full"},     32'(bus.ram_full),     32'd0);
    chk({tag, " overflow_err"}, 32'(bus.overflow_err), 32'd0);
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic nchk();
    @(negedge clk_2);
  endtask

  task automatic send(input logic [7:0] b);
    bus.avg_valid = 1'b1;
    bus.avg_data  = b;
    step();
    bus.avg_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Scoreboard monitor
  always @(negedge clk_2) begin
    if (bus.wr_ram === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected wr_ram: addr 0x%0h data 0x%08h, none expected",
                 bus.ram_addr, bus.ram_data);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr addr", 32'(bus.ram_addr), 32'(w.addr));
        chk("wr data", bus.ram_data, w.data);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.clr       = 1'b0;
    bus.avg_valid = 1'b0;
    bus.avg_data  = 8'h00;
    bus.ram_busy  = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    nchk();
    chk_rst("por");
    step();

    // Frame A, word 0: the basic pack and write
    bus.start = 1'b1; step(); bus.start = 1'b0;
    expect_wr(11'd0, 32'h44332211);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    nchk();
    chk("w0 wr_ram", 32'(bus.wr_ram), 32'd1);
    chk("w0 byte_cnt", 32'(bus.byte_cnt), 32'd0);
    step();
    repeat (WAIT_CYC) step();
    nchk();
    chk("w0 next addr", 32'(bus.ram_addr), 32'd1);
    chk("w0 next byte_cnt", 32'(bus.byte_cnt), 32'd0);
    chk("w0 next wr_ram", 32'(bus.wr_ram), 32'd0);

    // Word 1: ram_busy stalls the write for 3 cycles
    expect_wr(11'd1, 32'h88776655);
    send(8'h55); send(8'h66); send(8'h77);
    bus.ram_busy = 1'b1;
    send(8'h88);
    for (int i = 0; i < 3; i++) begin
      nchk();
      chk("busy wr_ram", 32'(bus.wr_ram), 32'd0);
      chk("busy ram_data", bus.ram_data, 32'h88776655);
      chk("busy ram_addr", 32'(bus.ram_addr), 32'd1);
      step();
    end
    bus.ram_busy = 1'b0;
    nchk();
    chk("busy release wr_ram", 32'(bus.wr_ram), 32'd1);
    step();
    nchk();
    chk("single pulse", 32'(bus.wr_ram), 32'd0);
    repeat (WAIT_CYC) step();

    // Word 2: AA held during WRITE, BB arrives on the WAIT exit cycle
    expect_wr(11'd2, 32'h04030201);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    bus.avg_valid = 1'b1; bus.avg_data = 8'hAA;
    step();
    bus.avg_valid = 1'b0;
    repeat (WAIT_CYC - 1) step();
    bus.avg_valid = 1'b1; bus.avg_data = 8'hBB;
    step();
    bus.avg_valid = 1'b0;
    nchk();
    chk("slip ram_data", bus.ram_data, 32'h0403BBAA);
    chk("slip byte_cnt", 32'(bus.byte_cnt), 32'd2);
    chk("slip overflow_err", 32'(bus.overflow_err), 32'd0);
    chk("slip ram_addr", 32'(bus.ram_addr), 32'd3);

    // Word 3: the last address, then FULL
    expect_wr(11'd3, 32'hDDCCBBAA);
    send(8'hCC); send(8'hDD);
    step();
    repeat (WAIT_CYC) step();
    nchk();
    chk("full ram_full", 32'(bus.ram_full), 32'd1);
    chk("full overflow_err", 32'(bus.overflow_err), 32'd0);
    chk("full ram_addr", 32'(bus.ram_addr), 32'd3);
    chk("full wr_ram", 32'(bus.wr_ram), 32'd0);
    send(8'h99);
    nchk();
    chk("full byte overflow_err", 32'(bus.overflow_err), 32'd1);
    chk("full stays", 32'(bus.ram_full), 32'd1);
    chk("full addr stays", 32'(bus.ram_addr), 32'd3);
    step();

    bus.clr = 1'b1; step(); bus.clr = 1'b0;
    nchk();
    chk_rst("clr full");

    // Frame B: two bytes during WRITE/WAIT, then clr mid-word with avg_valid
    bus.start = 1'b1; step(); bus.start = 1'b0;
    expect_wr(11'd0, 32'h40302010);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    bus.avg_valid = 1'b1; bus.avg_data = 8'h5A;
    step();
    bus.avg_valid = 1'b1; bus.avg_data = 8'h5B;
    step();
    bus.avg_valid = 1'b0;
    nchk();
    chk("drop overflow_err", 32'(bus.overflow_err), 32'd1);
    repeat (WAIT_CYC - 1) step();
    nchk();
    chk("held ram_data", bus.ram_data, 32'h4030205A);
    chk("held byte_cnt", 32'(bus.byte_cnt), 32'd1);
    chk("held ram_addr", 32'(bus.ram_addr), 32'd1);
    chk("sticky overflow_err", 32'(bus.overflow_err), 32'd1);
    send(8'h61);
    nchk();
    chk("mid byte_cnt", 32'(bus.byte_cnt), 32'd2);
    chk("mid ram_data", bus.ram_data, 32'h4030615A);
    chk("mid overflow_err", 32'(bus.overflow_err), 32'd1);
    bus.clr = 1'b1; bus.avg_valid = 1'b1; bus.avg_data = 8'h77;
    step();
    bus.clr = 1'b0; bus.avg_valid = 1'b0;
    nchk();
    chk_rst("clr mid");
    send(8'h55);
    nchk();
    chk("idle byte_cnt", 32'(bus.byte_cnt), 32'd0);
    chk("idle overflow_err", 32'(bus.overflow_err), 32'd0);

    // Frame C: restart from address 0, then reset during WRITE
    bus.start = 1'b1; step(); bus.start = 1'b0;
    expect_wr(11'd0, 32'hEFBEADDE);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    nchk();
    chk("restart wr_ram", 32'(bus.wr_ram), 32'd1);
    step();
    repeat (WAIT_CYC) step();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    reset = 1'b1;
    nchk();
    chk("reset write wr_ram", 32'(bus.wr_ram), 32'd0);
    step();
    reset = 1'b0;
    nchk();
    chk_rst("rst write");

    repeat (3) step();
    nchk();
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    chk("wr_ram count", 32'(n_wr), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
